// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared state encoding, register addresses and vector helper for interrupt_controller
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } intc_state_t;

    localparam logic [15:0] ADDR_IF    = 16'hFF0F;
    localparam logic [15:0] ADDR_IE    = 16'hFFFF;
    localparam logic [7:0]  VEC_BASE   = 8'h40;
    localparam logic [7:0]  VEC_STRIDE = 8'd8;

    function automatic logic [7:0] vec_of(input logic [2:0] idx);
        logic [7:0] idx8;
        idx8 = {5'b00000, idx};
        return VEC_BASE + idx8 * VEC_STRIDE;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - fixed-priority encoder, lowest pending index wins
module intc_prio_enc #(
    parameter int N_SRC = 5
) (
    input  logic [N_SRC-1:0] pending,
    output logic [2:0]       idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - Game Boy IF/IE interrupt controller; optional INTC_HALT_WAKE_EN adds wake output
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int N_SRC = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      A,
    input  logic [7:0]       Di,
    output logic [7:0]       Do,
    input  logic             wr_n,
    input  logic             rd_n,
    input  logic             cs,
    input  logic [N_SRC-1:0] src_req,
    output logic [N_SRC-1:0] src_ack,
    input  logic             ime,
    output logic             int_req,
    output logic [7:0]       int_vec,
`ifdef INTC_HALT_WAKE_EN
    output logic             wake,
`endif
    input  logic             cpu_ack
);

    intc_state_t      state;
    intc_state_t      state_next;
    logic [N_SRC-1:0] if_r;
    logic [N_SRC-1:0] if_next;
    logic [N_SRC-1:0] ie_r;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] ack_onehot;
    logic [7:0]       reg_out;
    logic [7:0]       vec_r;
    logic [7:0]       cur_vec;
    logic [7:0]       if_rd;
    logic [7:0]       ie_rd;
    logic [2:0]       idx;
    logic             valid;
    logic             fire;
    logic             wr_if;
    logic             wr_ie;
    logic             rd_stb;
    logic             unused_di;

    assign unused_di = ^Di;

    assign rise    = src_req & ~src_q;
    assign pending = if_r & ie_r;
    assign wr_if   = cs & ~wr_n & (A == ADDR_IF);
    assign wr_ie   = cs & ~wr_n & (A == ADDR_IE);
    assign rd_stb  = cs & ~rd_n & wr_n;
    assign cur_vec = vec_of(idx);

    intc_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .pending (pending),
        .idx     (idx),
        .valid   (valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ime && valid) state_next = ST_REQ;
            ST_REQ: begin
                if (!ime || !valid) begin
                    state_next = ST_IDLE;
                end else if (cpu_ack) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outside REQ, or once software has emptied pending, the vector freezes.
    always_comb begin
        int_req = (state == ST_REQ);
        fire    = (state == ST_REQ) && ime && valid && cpu_ack;
        int_vec = ((state == ST_REQ) && valid) ? cur_vec : vec_r;
    end

    // A fresh edge is OR'd in last so it survives both a bus write of 0 and the ack clear.
    always_comb begin
        if_next = if_r;
        if (wr_if) begin
            if_next = Di[N_SRC-1:0];
        end
        if (fire) begin
            if_next[idx] = 1'b0;
        end
        if_next = if_next | rise;
    end

    always_comb begin
        if_rd = 8'hFF;
        if_rd[N_SRC-1:0] = if_r;
        ie_rd = 8'h00;
        ie_rd[N_SRC-1:0] = ie_r;
        ack_onehot = '0;
        ack_onehot[idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_r    <= '0;
            ie_r    <= '0;
            src_q   <= '0;
            src_ack <= '0;
            reg_out <= 8'h00;
            vec_r   <= 8'h00;
        end else begin
            src_q   <= src_req;
            if_r    <= if_next;
            src_ack <= fire ? ack_onehot : '0;
            if (wr_ie) begin
                ie_r <= Di[N_SRC-1:0];
            end
            if ((state == ST_REQ) && valid) begin
                vec_r <= cur_vec;
            end
            if (rd_stb && (A == ADDR_IF)) begin
                reg_out <= if_rd;
            end else if (rd_stb && (A == ADDR_IE)) begin
                reg_out <= ie_rd;
            end
        end
    end

`ifdef INTC_HALT_WAKE_EN
    // Wake ignores ime so a halted CPU resumes even with interrupts masked.
    always_ff @(posedge clock) begin
        if (reset) begin
            wake <= 1'b0;
        end else begin
            wake <= |pending;
        end
    end
`endif

    assign Do = cs ? reg_out : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - table-driven directed bench for interrupt_controller
module tb_interrupt_controller;

    logic        clock;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  Di;
    wire  [7:0]  Do;
    logic        wr_n;
    logic        rd_n;
    logic        cs;
    logic [4:0]  src_req;
    logic [4:0]  src_ack;
    logic        ime;
    logic        int_req;
    logic [7:0]  int_vec;
    logic        cpu_ack;
`ifdef INTC_HALT_WAKE_EN
    logic        wake;
`endif

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.N_SRC(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .A       (A),
        .Di      (Di),
        .Do      (Do),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .cs      (cs),
        .src_req (src_req),
        .src_ack (src_ack),
        .ime     (ime),
        .int_req (int_req),
        .int_vec (int_vec),
`ifdef INTC_HALT_WAKE_EN
        .wake    (wake),
`endif
        .cpu_ack (cpu_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [7:0]  di;
        logic        wr;
        logic        rd;
        logic [4:0]  src;
        logic        ime;
        logic        ack;
        logic        e_req;
        logic [7:0]  e_vec;
        logic [4:0]  e_sack;
        logic [7:0]  e_do;
    } vec_t;

    vec_t tbl[$];

    localparam logic [15:0] AF = 16'hFF0F;
    localparam logic [15:0] AE = 16'hFFFF;

    function automatic vec_t mk(logic rst, logic [15:0] a, logic [7:0] di, logic wr, logic rd,
                                logic [4:0] src, logic im, logic ack,
                                logic e_req, logic [7:0] e_vec, logic [4:0] e_sack, logic [7:0] e_do);
        vec_t v;
        v.rst = rst; v.a = a; v.di = di; v.wr = wr; v.rd = rd;
        v.src = src; v.ime = im; v.ack = ack;
        v.e_req = e_req; v.e_vec = e_vec; v.e_sack = e_sack; v.e_do = e_do;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [15:0] a, logic [7:0] di, logic wr, logic rd,
                         logic [4:0] src, logic im, logic ack);
        reset   = rst;
        A       = a;
        Di      = di;
        wr_n    = ~wr;
        rd_n    = ~rd;
        cs      = wr | rd;
        src_req = src;
        ime     = im;
        cpu_ack = ack;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b1, AF, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0);

        //          rst a   di    wr rd src    ime ack  req vec    sack   do
        tbl.push_back(mk(1, AF, 8'h00, 0, 0, 5'h00, 0, 0,  0, 8'h00, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 1, 5'h00, 0, 0,  0, 8'h00, 5'h00, 8'hE0));
        tbl.push_back(mk(0, AE, 8'h00, 0, 1, 5'h00, 0, 0,  0, 8'h00, 5'h00, 8'h00));
        tbl.push_back(mk(0, AE, 8'h04, 1, 0, 5'h00, 1, 0,  0, 8'h00, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h04, 1, 0,  0, 8'h00, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 1, 5'h04, 1, 0,  1, 8'h50, 5'h00, 8'hE4));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h04, 1, 1,  0, 8'h50, 5'h04, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 1, 5'h00, 1, 0,  0, 8'h50, 5'h00, 8'hE0));
        tbl.push_back(mk(0, AE, 8'h1F, 1, 0, 5'h00, 1, 0,  0, 8'h50, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 0,  0, 8'h50, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 0,  1, 8'h48, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 1,  0, 8'h48, 5'h02, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 0,  0, 8'h48, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 0,  1, 8'h60, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h12, 1, 1,  0, 8'h60, 5'h10, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h00, 1, 0,  0, 8'h60, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h01, 0, 0,  0, 8'h60, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h01, 0, 0,  0, 8'h60, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h01, 1, 0,  1, 8'h40, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 1, 0, 5'h01, 1, 0,  1, 8'h40, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 0, 5'h00, 1, 0,  0, 8'h40, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h08, 1, 0, 5'h04, 0, 0,  0, 8'h40, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 1, 5'h04, 0, 0,  0, 8'h40, 5'h00, 8'hEC));
        tbl.push_back(mk(0, AF, 8'h00, 1, 0, 5'h04, 0, 1,  0, 8'h40, 5'h00, 8'h00));
        tbl.push_back(mk(0, AF, 8'h00, 0, 1, 5'h04, 0, 0,  0, 8'h40, 5'h00, 8'hE0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].a, tbl[i].di, tbl[i].wr, tbl[i].rd,
                  tbl[i].src, tbl[i].ime, tbl[i].ack);
            tick();
            chk($sformatf("row%0d int_req", i), 32'(int_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d int_vec", i), 32'(int_vec), 32'(tbl[i].e_vec));
            chk($sformatf("row%0d src_ack", i), 32'(src_ack), 32'(tbl[i].e_sack));
            if (tbl[i].rd) begin
                chk($sformatf("row%0d Do", i), 32'(Do), 32'(tbl[i].e_do));
            end
        end

        // Rising edge on bit 2 in the same cycle as its cpu_ack keeps IF[2] set.
        drive(0, AF, 8'h00, 0, 0, 5'h00, 1, 0); tick();
        drive(0, AF, 8'h00, 0, 0, 5'h04, 1, 0); tick();
        drive(0, AF, 8'h00, 0, 0, 5'h04, 1, 0); tick();
        chk("edge_ack req", 32'(int_req), 32'd1);
        chk("edge_ack vec", 32'(int_vec), 32'h50);
        drive(0, AF, 8'h00, 0, 0, 5'h00, 1, 0); tick();
        chk("edge_ack hold", 32'(int_req), 32'd1);
        drive(0, AF, 8'h00, 0, 0, 5'h04, 1, 1); tick();
        chk("edge_ack sack", 32'(src_ack), 32'h04);
        chk("edge_ack req_low", 32'(int_req), 32'd0);
        drive(0, AF, 8'h00, 0, 1, 5'h04, 1, 0); tick();
        chk("edge_ack if_read", 32'(Do), 32'hE4);
        chk("edge_ack sack_one", 32'(src_ack), 32'h00);
        drive(0, AF, 8'h00, 0, 0, 5'h04, 1, 0); tick();
        chk("edge_ack rereq", 32'(int_req), 32'd1);
        chk("edge_ack revec", 32'(int_vec), 32'h50);

        // Reset while in REQ with a concurrent cpu_ack.
        drive(1, AF, 8'h00, 0, 0, 5'h00, 1, 1); tick();
        chk("rst_req int_req", 32'(int_req), 32'd0);
        chk("rst_req src_ack", 32'(src_ack), 32'h00);
        chk("rst_req int_vec", 32'(int_vec), 32'h00);
        drive(0, AF, 8'h00, 0, 1, 5'h00, 1, 0); tick();
        chk("rst_req if", 32'(Do), 32'hE0);
        drive(0, AE, 8'h00, 0, 1, 5'h00, 1, 0); tick();
        chk("rst_req ie", 32'(Do), 32'h00);
        chk("rst_req sack2", 32'(src_ack), 32'h00);

`ifdef INTC_HALT_WAKE_EN
        chk("wake reset", 32'(wake), 32'd0);
        drive(0, AE, 8'h01, 1, 0, 5'h00, 0, 0); tick();
        drive(0, AF, 8'h00, 0, 0, 5'h01, 0, 0); tick();
        drive(0, AF, 8'h00, 0, 0, 5'h01, 0, 0); tick();
        chk("wake set", 32'(wake), 32'd1);
        chk("wake no_req", 32'(int_req), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Game Boy interrupt controller. It owns the IF (FF0F) and IE (FFFF) registers and latches rising edges of level requests from the timer, LCD and other sources. It selects the highest-priority enabled pending source, presents a request and vector to the CPU, and on CPU acknowledge clears the IF bit and returns a one-cycle acknowledge to the originating source. It sits on the CPU register bus beside the timer.

## Interface
- N_SRC, 5, number of interrupt sources (1–5); source i maps to IF/IE bit i, vector 8'h40 + 8*i
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- A  in  16  bus address
- Di  in  8  write data
- Do  out  8  read data; reg_out when cs, else 8'hZZ
- wr_n  in  1  write strobe, active-low
- rd_n  in  1  read strobe, active-low
- cs  in  1  chip select for FF0F/FFFF
- src_req  in  N_SRC  level requests; bit 0 VBlank, 1 STAT, 2 timer, 3 serial, 4 joypad
- src_ack  out  N_SRC  one-cycle acknowledge pulse per source
- ime  in  1  CPU master interrupt enable
- int_req  out  1  interrupt request to CPU
- int_vec  out  8  dispatch vector, valid while int_req=1
- cpu_ack  in  1  one-cycle CPU dispatch acknowledge

## Operation
- Edge detect: src_q <= src_req each cycle. A rising edge (src_req & ~src_q) sets IF[i].
- Writes (cs & !wr_n): FF0F sets IF <= Di[N_SRC-1:0]; FFFF sets IE <= Di[N_SRC-1:0].
- Reads (cs & !rd_n, wr_n high): reg_out <= {1s in bits 7:N_SRC, IF} for FF0F and {3'b000, IE} for FFFF. Other addresses leave reg_out unchanged.
- pending = IF & IE. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: if ime & |pending, go to REQ.
  - REQ: int_req=1; int_vec tracks the highest-priority pending source every cycle.
    - If pending becomes 0 (software cleared IF/IE) or ime drops, go to IDLE with int_req=0.
    - On cpu_ack: latch idx, clear IF[idx], pulse src_ack[idx], go to ACK.
  - ACK: int_req=0; return to IDLE next cycle. This gives the CPU one cycle to clear ime.
- Simultaneous events on the same bit, same cycle:
  - A rising edge beats a bus write of 0 and beats the clear from cpu_ack. The bit stays 1 and the new event is not lost.
  - A bus write to other bits proceeds normally.
- cpu_ack outside REQ is ignored.

## Timing
- Reset values: IF=0, IE=0, src_q=0, reg_out=8'h00, int_req=0, int_vec=8'h00, src_ack=0, state IDLE.
- Reset mid-REQ drops int_req the next cycle. No src_ack is issued.
- Source edge at cycle N: IF bit visible at N+1. int_req rises at N+2, given IE set and ime=1.
- Read: Do reflects the register one cycle after the strobe cycle.
- cpu_ack at cycle M: IF clear and src_ack high at M+1 for exactly one cycle; int_req low at M+1.
- Back-to-back: a second pending source reasserts int_req no earlier than M+2.
- int_vec holds its last value when int_req=0.

## Configuration
- INTC_HALT_WAKE_EN:
  - Defined: adds output port wake (1 bit, reset 0), registered as |pending independent of ime, so a halted CPU wakes even with interrupts disabled.
  - Undefined: no wake port, no logic.

## Structure
- Package intc_pkg holds the state encoding (IDLE/REQ/ACK), ADDR_IF=16'hFF0F, ADDR_IE=16'hFFFF, VEC_BASE=8'h40, VEC_STRIDE=8.
- Sub-module intc_prio_enc: combinational; takes pending[N_SRC-1:0] and produces idx[2:0] and valid.

## Test plan
- Reset, then read FF0F and FFFF -> 8'hE0 and 8'h00 (N_SRC=5).
- IE=8'h04, ime=1, src_req[2] rises -> IF=8'hE4, int_req high 2 cycles later, int_vec=8'h50. cpu_ack -> src_ack=5'b00100 for one cycle, IF=8'hE0.
- IE=8'h1F, edges on bits 4 and 1 in the same cycle -> int_vec=8'h48. After its ack, int_req returns with int_vec=8'h60.
- ime=0 with bit 0 pending -> int_req stays 0. With INTC_HALT_WAKE_EN, wake=1. Raising ime -> int_req after 1 cycle.
- In REQ, write FF0F=8'h00 -> int_req drops, state IDLE, no src_ack.
- Bus write FF0F=8'h00 in the same cycle as a rising src_req[2] -> IF bit 2 reads 1.
